rr_arbiter8_ctrl: RTL and testbench

RR_ARBITER8_CTRL -- requirements
Module: rr_arbiter8_ctrl

---
 rtl/rr_arbiter8_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_rr_arbiter8_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8_ctrl.sv
// -----------------------------------------------------------------------------
// rr_arbiter8_ctrl
//
// Eight-way round-robin arbiter with a hold-time limit on each grant.
//
// A three-state controller (IDLE -> GRANT -> RELEASE -> IDLE) hands the
// shared resource to one requester at a time. The search for the next grantee
// starts at the priority pointer. On every exit from GRANT the pointer moves
// to one past the last grantee, so a requester that keeps requesting after its
// grant ends is searched last in the next arbitration.
//
// A grant ends on the first rising edge where any of these is true:
//   en low, done high, the grantee drops its request, or the grant has been
//   held for HOLD_MAX cycles.
// Only the last cause (the hold limit) raises the one-cycle timeout pulse,
// which appears during the RELEASE cycle.
//
// Parameters
//   HOLD_MAX  maximum number of cycles one grant may be held (1..255)
//   CNT_W     width of the hold counter; must be able to hold HOLD_MAX
//
// Ports
//   clk        in   1  sole clock; all state changes on its rising edge
//   rst_n      in   1  asynchronous active-low reset
//   en         in   1  arbiter enable; low blocks new grants and ends the
//                      current one
//   req        in   8  request vector; bit i belongs to requester i
//   done       in   1  grantee finished; only looked at in GRANT
//   gnt        out  8  one-hot grant, registered (zero outside GRANT)
//   gnt_idx    out  3  binary index of the current or last grantee, registered
//   gnt_valid  out  1  high exactly when gnt is non-zero, registered
//   timeout    out  1  one-cycle pulse when a grant hits the hold limit
// -----------------------------------------------------------------------------
module rr_arbiter8_ctrl #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [2:0]       r_ptr;        // first index searched at the next arbitration
  logic [CNT_W-1:0] r_hold_cnt;   // cycles the current grant has been held
  logic [7:0]       r_gnt;
  logic [2:0]       r_gnt_idx;
  logic             r_gnt_valid;
  logic             r_timeout;

  // ---------------------------------------------------------------------------
  // Round-robin selection
  //
  // The request vector is rotated right by the pointer so that the bit to be
  // searched first lands at position 0. A priority search from bit 0 upward
  // then gives the offset of the winner from the pointer, and adding the
  // pointer back (modulo 8 through 3-bit wrap) gives its absolute index.
  // ---------------------------------------------------------------------------
  logic [7:0] w_req_rot;
  logic [2:0] w_sel_off;
  logic [2:0] w_sel_idx;
  logic       w_any_req;

  always_comb begin
    // NOTE: every variable written here gets a value before any condition, so
    // no path leaves it unassigned and no latch can be inferred.
    w_req_rot = (req >> r_ptr) | (req << (4'd8 - {1'b0, r_ptr}));
    w_sel_off = 3'd0;
    // Walking downward means the lowest set bit is written last and wins.
    for (int k = 7; k >= 0; k--) begin
      if (w_req_rot[k]) begin
        w_sel_off = 3'(k);
      end
    end
    w_sel_idx = r_ptr + w_sel_off;
    w_any_req = |req;
  end

  // ---------------------------------------------------------------------------
  // Grant exit conditions, listed in decreasing priority. Only the first true
  // condition is the cause of the exit; the cause matters only for deciding
  // whether the hold limit should be reported.
  // ---------------------------------------------------------------------------
  logic w_exit_en;
  logic w_exit_done;
  logic w_exit_drop;
  logic w_exit_hold;
  logic w_exit;
  logic w_cause_hold;

  always_comb begin
    w_exit_en    = ~en;
    w_exit_done  = done;
    w_exit_drop  = ~req[r_gnt_idx];
    w_exit_hold  = (r_hold_cnt == HOLD_LIMIT);
    w_exit       = w_exit_en | w_exit_done | w_exit_drop | w_exit_hold;
    w_cause_hold = w_exit_hold & ~w_exit_en & ~w_exit_done & ~w_exit_drop;
  end

  // ---------------------------------------------------------------------------
  // Controller with registered outputs
  //
  // Reset is asynchronous, so asserting rst_n during GRANT clears gnt at once
  // without passing through RELEASE and without a timeout pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the values from before the edge, whatever the statement order.
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= 3'd0;
      r_hold_cnt  <= '0;
      r_gnt       <= 8'h00;
      r_gnt_idx   <= 3'd0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      // timeout is a pulse: it is high only in the cycle after the edge that
      // raised it.
      r_timeout <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (en && w_any_req) begin
            r_state     <= S_GRANT;
            r_gnt_idx   <= w_sel_idx;
            r_gnt       <= 8'h01 << w_sel_idx;
            r_gnt_valid <= 1'b1;
            // The first grant cycle counts as cycle 1 of the hold time.
            r_hold_cnt  <= CNT_ONE;
          end else begin
            r_gnt       <= 8'h00;
            r_gnt_valid <= 1'b0;
          end
        end

        S_GRANT: begin
          if (w_exit) begin
            r_state     <= S_RELEASE;
            r_gnt       <= 8'h00;
            r_gnt_valid <= 1'b0;
            r_ptr       <= r_gnt_idx + 3'd1;
            r_timeout   <= w_cause_hold;
          end else if (r_hold_cnt != HOLD_LIMIT) begin
            // Saturating count; the grant normally leaves before the limit
            // would be passed.
            r_hold_cnt <= r_hold_cnt + CNT_ONE;
          end
        end

        S_RELEASE: begin
          // One mandatory gap cycle with no grant before arbitrating again.
          r_state     <= S_IDLE;
          r_gnt       <= 8'h00;
          r_gnt_valid <= 1'b0;
        end

        default: begin
          r_state     <= S_IDLE;
          r_gnt       <= 8'h00;
          r_gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter8_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter8_ctrl
//
// Directed bench for rr_arbiter8_ctrl with the default HOLD_MAX of 15.
// Inputs are changed 1 ns after a rising edge and outputs are sampled at the
// same point, so every sample sees the state left by the preceding edge.
// -----------------------------------------------------------------------------
module tb_rr_arbiter8_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_asserts;
  int n_fails;

  rr_arbiter8_ctrl #(
    .HOLD_MAX(15),
    .CNT_W   (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Check all four outputs at once.
  task automatic check_out(input string tag, input logic [7:0] e_gnt,
                           input logic [2:0] e_idx, input logic e_valid,
                           input logic e_to);
    check({tag, ".gnt"},       32'(gnt),       32'(e_gnt));
    check({tag, ".gnt_idx"},   32'(gnt_idx),   32'(e_idx));
    check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(e_valid));
    check({tag, ".timeout"},   32'(timeout),   32'(e_to));
  endtask

  // Check only grant presence and timeout (gnt_idx holds its last value).
  task automatic check_gap(input string tag, input logic e_to);
    check({tag, ".gnt"},       32'(gnt),       32'h0);
    check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'h0);
    check({tag, ".timeout"},   32'(timeout),   32'(e_to));
  endtask

  initial begin
    logic [7:0] e_gnt;
    n_asserts = 0;
    n_fails   = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    done  = 1'b0;

    // ---------------- Reset state ----------------
    #12;
    check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check_out("idle_en0", 8'h00, 3'd0, 1'b0, 1'b0);

    // ---------------- Basic grant, done, next requester ----------------
    en  = 1'b1;
    req = 8'h24;
    check_out("lat_before", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    check_out("b_g2", 8'h04, 3'd2, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    check_gap("b_rel", 1'b0);
    tick();
    check_gap("b_idle", 1'b0);
    tick();
    check_out("b_g5", 8'h20, 3'd5, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 8'h00;
    tick();
    tick();
    check_out("b_idle_noreq", 8'h00, 3'd5, 1'b0, 1'b0);

    // ---------------- Full request sweep from index 0 ----------------
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      e_gnt = 8'h01 << (k % 8);
      tick();
      check_out($sformatf("rr%0d_c1", k), e_gnt, 3'(k % 8), 1'b1, 1'b0);
      tick();
      check($sformatf("rr%0d_c2.gnt", k), 32'(gnt), 32'(e_gnt));
      done = 1'b1;
      tick();
      done = 1'b0;
      check_gap($sformatf("rr%0d_rel", k), 1'b0);
      tick();
      check_gap($sformatf("rr%0d_idle", k), 1'b0);
    end
    req = 8'h00;
    tick();

    // ---------------- Hold limit and timeout ----------------
    req = 8'h01;
    tick();
    check_out("hold_c1", 8'h01, 3'd0, 1'b1, 1'b0);
    for (int c = 2; c <= 15; c++) begin
      tick();
      check_out($sformatf("hold_c%0d", c), 8'h01, 3'd0, 1'b1, 1'b0);
    end
    tick();
    check_gap("hold_rel", 1'b1);
    tick();
    check_gap("hold_idle", 1'b0);
    tick();
    check_out("hold_regrant", 8'h01, 3'd0, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 8'h00;
    tick();
    tick();

    // ---------------- en=0 and done on the same edge ----------------
    req = 8'h08;
    tick();
    check_out("en_g3", 8'h08, 3'd3, 1'b1, 1'b0);
    en   = 1'b0;
    done = 1'b1;
    req  = 8'h18;
    tick();
    done = 1'b0;
    check_gap("en_rel", 1'b0);
    tick();
    check_gap("en_idle1", 1'b0);
    tick();
    check_gap("en_idle2", 1'b0);
    tick();
    check_gap("en_idle3", 1'b0);
    // Pointer now at 4, so requester 4 beats requester 3.
    en = 1'b1;
    tick();
    check_out("en_g4", 8'h10, 3'd4, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 8'h00;
    tick();
    tick();

    // ---------------- Reset during a grant ----------------
    req = 8'h40;
    tick();
    check_out("rst_g6", 8'h40, 3'd6, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_out("rst_async", 8'h00, 3'd0, 1'b0, 1'b0);
    req = 8'h81;
    tick();
    check_out("rst_held", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check_out("rst_g0", 8'h01, 3'd0, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 8'h00;
    tick();
    tick();

    // ---------------- Grantee drops its request ----------------
    req = 8'h02;
    tick();
    check_out("drop_c1", 8'h02, 3'd1, 1'b1, 1'b0);
    req = 8'h0A;   // other bits changing mid-grant have no effect
    tick();
    check_out("drop_c2", 8'h02, 3'd1, 1'b1, 1'b0);
    tick();
    check_out("drop_c3", 8'h02, 3'd1, 1'b1, 1'b0);
    req = 8'h08;
    tick();
    check_gap("drop_rel", 1'b0);
    tick();
    check_gap("drop_idle", 1'b0);
    tick();
    check_out("drop_g3", 8'h08, 3'd3, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fails);
    $finish;
  end

endmodule
